dm_port_arbiter: RTL and testbench

- Shares the single data-memory port of MEM (dm_addr/dm_we/dm_type/dm_din/dm_dout) between two requesters: the CPU MEM stage and the debug/loader requester (PDU program and data load/inspect).
- Sits between CPU and MEM at top level.
- Serialises transactions, one outstanding at a time, with round-robin fairness.
- Produces the CPU stall signal.

---
 rtl/dm_arb_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 17 +
 rtl/dm_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// State encoding, owner codes and MEM access-size codes.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam logic [2:0] MT_LB  = 3'd0;
  localparam logic [2:0] MT_LH  = 3'd1;
  localparam logic [2:0] MT_LW  = 3'd2;
  localparam logic [2:0] MT_LBU = 3'd3;
  localparam logic [2:0] MT_LHU = 3'd4;
  localparam logic [2:0] MT_SB  = 3'd5;
  localparam logic [2:0] MT_SH  = 3'd6;
  localparam logic [2:0] MT_SW  = 3'd7;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: req[0]=CPU, req[1]=DBG.
// On a tie the requester that did not win last time is granted.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req)
      grant = (last_owner == OWN_DBG) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the MEM data port between CPU and debug requesters.
// Define DM_ARB_PERF_EN to add saturating stall/grant counters.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_type,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_type,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_we,
  output logic [2:0]        dm_type,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_stall_cnt,
  output logic [31:0]       perf_cpu_grant_cnt,
  output logic [31:0]       perf_dbg_grant_cnt
`endif
);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        grant;
  logic              last_owner;
  logic              own;
  logic              lat_we;
  logic [2:0]        lat_type;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        cnt;
  logic              win;
  logic              sample;

  rr_arb2 u_rr (
    .req        ({dbg_req, cpu_req}),
    .last_owner (last_owner),
    .grant      (grant)
  );

  assign win = (state == IDLE) && (|grant);

  assign sample = ((state == ISSUE) && !lat_we && (RD_LAT == 0))
               || ((state == WAIT) && (cnt == 2'd1));

  assign dm_addr = lat_addr;
  assign dm_type = lat_type;
  assign dm_din  = lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (|grant) state_nx = ISSUE;
      ISSUE: begin
        if (lat_we)           state_nx = IDLE;
        else if (RD_LAT == 0) state_nx = RESP;
        else                  state_nx = WAIT;
      end
      WAIT:  if (cnt == 2'd1) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready  = 1'b0;
    dbg_ready  = 1'b0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    dm_we      = 1'b0;
    unique case (state)
      IDLE: if (!rst) begin
        cpu_ready = grant[0];
        dbg_ready = grant[1];
      end
      ISSUE: dm_we = lat_we;
      RESP: begin
        cpu_rvalid = (own == OWN_CPU);
        dbg_rvalid = (own == OWN_DBG);
      end
      default: ;
    endcase
    cpu_stall = (cpu_req && !cpu_ready)
             || ((state != IDLE) && (own == OWN_CPU));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_DBG;
      own        <= OWN_CPU;
      lat_we     <= 1'b0;
      lat_type   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      if (win) begin
        own        <= grant[1];
        last_owner <= grant[1];
        if (grant[1]) begin
          lat_we    <= dbg_we;
          lat_type  <= dbg_type;
          lat_addr  <= dbg_addr;
          lat_wdata <= dbg_wdata;
        end else begin
          lat_we    <= cpu_we;
          lat_type  <= cpu_type;
          lat_addr  <= cpu_addr;
          lat_wdata <= cpu_wdata;
        end
      end
      if (state == ISSUE)     cnt <= 2'(RD_LAT);
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (sample) begin
        if (own == OWN_DBG) dbg_rdata <= dm_dout;
        else                cpu_rdata <= dm_dout;
      end
    end
  end

`ifdef DM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cpu_stall_cnt <= '0;
      perf_cpu_grant_cnt <= '0;
      perf_dbg_grant_cnt <= '0;
    end else begin
      if (cpu_stall) perf_cpu_stall_cnt <= sat_inc(perf_cpu_stall_cnt);
      if (cpu_ready) perf_cpu_grant_cnt <= sat_inc(perf_cpu_grant_cnt);
      if (dbg_ready) perf_dbg_grant_cnt <= sat_inc(perf_dbg_grant_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: u1 uses RD_LAT=1, u3 uses RD_LAT=3.
// Each instance has its own behavioural memory with matching read latency.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we, dbg_we;
  logic [2:0]  cpu_type, dbg_type;
  logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
  logic        cpu_req1, dbg_req1, cpu_req3, dbg_req3;

  logic        cpu_ready1, cpu_rvalid1, cpu_stall1;
  logic        dbg_ready1, dbg_rvalid1, dm_we1;
  logic [31:0] cpu_rdata1, dbg_rdata1, dm_addr1, dm_din1, dout1;
  logic [2:0]  dm_type1;

  logic        cpu_ready3, cpu_rvalid3, cpu_stall3;
  logic        dbg_ready3, dbg_rvalid3, dm_we3;
  logic [31:0] cpu_rdata3, dbg_rdata3, dm_addr3, dm_din3;
  logic [2:0]  dm_type3;
  logic [31:0] p3a, p3b, p3c;

`ifdef DM_ARB_PERF_EN
  logic [31:0] ps1, pc1, pd1, ps3, pc3, pd3;
`endif

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(cpu_we), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready1), .cpu_rvalid(cpu_rvalid1),
    .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .dbg_req(dbg_req1), .dbg_we(dbg_we), .dbg_type(dbg_type),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready1), .dbg_rvalid(dbg_rvalid1),
    .dbg_rdata(dbg_rdata1),
    .dm_addr(dm_addr1), .dm_we(dm_we1), .dm_type(dm_type1),
    .dm_din(dm_din1), .dm_dout(dout1)
`ifdef DM_ARB_PERF_EN
    , .perf_cpu_stall_cnt(ps1), .perf_cpu_grant_cnt(pc1),
    .perf_dbg_grant_cnt(pd1)
`endif
  );

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_type(cpu_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready3), .cpu_rvalid(cpu_rvalid3),
    .cpu_rdata(cpu_rdata3), .cpu_stall(cpu_stall3),
    .dbg_req(dbg_req3), .dbg_we(dbg_we), .dbg_type(dbg_type),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready3), .dbg_rvalid(dbg_rvalid3),
    .dbg_rdata(dbg_rdata3),
    .dm_addr(dm_addr3), .dm_we(dm_we3), .dm_type(dm_type3),
    .dm_din(dm_din3), .dm_dout(p3c)
`ifdef DM_ARB_PERF_EN
    , .perf_cpu_stall_cnt(ps3), .perf_cpu_grant_cnt(pc3),
    .perf_dbg_grant_cnt(pd3)
`endif
  );

  always @(posedge clk) begin
    if (dm_we1) mem1[dm_addr1[11:2]] <= dm_din1;
    dout1 <= mem1[dm_addr1[11:2]];
  end

  always @(posedge clk) begin
    if (dm_we3) mem3[dm_addr3[11:2]] <= dm_din3;
    p3a <= mem3[dm_addr3[11:2]];
    p3b <= p3a;
    p3c <= p3b;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    int order [6];
    logic seen;
    logic [31:0] rd;

    rst = 1'b1;
    cpu_req1 = 0; dbg_req1 = 0; cpu_req3 = 0; dbg_req3 = 0;
    cpu_we = 0; dbg_we = 0; cpu_type = '0; dbg_type = '0;
    cpu_addr = '0; dbg_addr = '0; cpu_wdata = '0; dbg_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(u1.state), 32'(IDLE));
    chk("rst_ready", 32'({cpu_ready1, dbg_ready1}), 32'd0);
    chk("rst_rvalid", 32'({cpu_rvalid1, dbg_rvalid1}), 32'd0);
    chk("rst_rdata", cpu_rdata1 | dbg_rdata1, 32'd0);
    chk("rst_we", 32'(dm_we1), 32'd0);
    chk("rst_bus", dm_addr1 | dm_din1 | 32'(dm_type1), 32'd0);

    // CPU write
    cpu_req1 = 1; cpu_we = 1; cpu_addr = 32'h100;
    cpu_wdata = 32'hDEADBEEF; cpu_type = MT_SW;
    #1;
    chk("w_ready", 32'(cpu_ready1), 32'd1);
    chk("w_we_c0", 32'(dm_we1), 32'd0);
    tick();
    cpu_req1 = 0; cpu_we = 0;
    #1;
    chk("w_we_c1", 32'(dm_we1), 32'd1);
    chk("w_addr", dm_addr1, 32'h100);
    chk("w_din", dm_din1, 32'hDEADBEEF);
    chk("w_type", 32'(dm_type1), 32'(MT_SW));
    tick();
    chk("w_we_c2", 32'(dm_we1), 32'd0);
    chk("w_state_c2", 32'(u1.state), 32'(IDLE));
    chk("w_addr_hold", dm_addr1, 32'h100);

    // CPU read-back
    cpu_req1 = 1; cpu_we = 0; cpu_type = MT_LW; cpu_addr = 32'h100;
    #1;
    chk("r_ready", 32'(cpu_ready1), 32'd1);
    tick();
    cpu_req1 = 0;
    lat = 0; seen = 0; rd = '0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (dbg_rvalid1) seen = 1;
      if (cpu_rvalid1 && lat == 0) begin
        lat = k;
        rd = cpu_rdata1;
      end
      tick();
    end
    chk("r_latency", lat, 3);
    chk("r_data", rd, 32'hDEADBEEF);
    chk("r_dbg_rvalid", 32'(seen), 32'd0);

    // DBG write of 0x0 so the next CPU read has known data
    dbg_req1 = 1; dbg_we = 1; dbg_addr = 32'h0;
    dbg_wdata = 32'h0BADF00D; dbg_type = MT_SW;
    #1;
    chk("dw_ready", 32'(dbg_ready1), 32'd1);
    chk("dw_cpu_ready", 32'(cpu_ready1), 32'd0);
    tick();
    dbg_req1 = 0;
    #1;
    chk("dw_we", 32'(dm_we1), 32'd1);
    chk("dw_din", dm_din1, 32'h0BADF00D);
    tick();
    tick();

    // Simultaneous requests out of reset
    rst = 1;
    tick();
    rst = 0;
    cpu_req1 = 1; cpu_we = 0; cpu_addr = 32'h0; cpu_type = MT_LW;
    dbg_req1 = 1; dbg_we = 1; dbg_addr = 32'h200;
    dbg_wdata = 32'h12345678; dbg_type = MT_SW;
    #1;
    chk("s_cpu_first", 32'(cpu_ready1), 32'd1);
    chk("s_dbg_wait", 32'(dbg_ready1), 32'd0);
    chk("s_stall_c0", 32'(cpu_stall1), 32'd0);
    tick();
    cpu_req1 = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("s_stall_c%0d", k), 32'(cpu_stall1), 32'd1);
      chk($sformatf("s_dbg_hold_c%0d", k), 32'(dbg_ready1), 32'd0);
      chk($sformatf("s_rvalid_c%0d", k), 32'(cpu_rvalid1),
          (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("s_rdata", cpu_rdata1, 32'h0BADF00D);
      tick();
    end
    #1;
    chk("s_dbg_ready", 32'(dbg_ready1), 32'd1);
    chk("s_stall_c4", 32'(cpu_stall1), 32'd0);
    tick();
    dbg_req1 = 0; dbg_we = 0;
    #1;
    chk("s_dbg_we", 32'(dm_we1), 32'd1);
    chk("s_dbg_addr", dm_addr1, 32'h200);
    chk("s_dbg_din", dm_din1, 32'h12345678);
    tick();
`ifdef DM_ARB_PERF_EN
    chk("p_cpu_grant", pc1, 32'd1);
    chk("p_dbg_grant", pd1, 32'd1);
    chk("p_cpu_stall", ps1, 32'd3);
`endif

    // Continuous contention: writes from both sides
    cpu_req1 = 1; dbg_req1 = 1; cpu_we = 1; dbg_we = 1;
    cpu_addr = 32'h300; dbg_addr = 32'h304;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      if (cpu_ready1 && dbg_ready1) begin
        order[n] = 2;
        n++;
      end else if (cpu_ready1) begin
        order[n] = 0;
        n++;
      end else if (dbg_ready1) begin
        order[n] = 1;
        n++;
      end
      tick();
    end
    cpu_req1 = 0; dbg_req1 = 0; cpu_we = 0; dbg_we = 0;
    chk("c_grants", n, 6);
    for (int i = 0; i < n; i++)
      chk($sformatf("c_order%0d", i), order[i], i % 2);
    tick();
    tick();

    // Reset in the middle of a RD_LAT=3 read
    cpu_req3 = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_type = MT_LW;
    #1;
    chk("x_ready", 32'(cpu_ready3), 32'd1);
    tick();
    cpu_req3 = 0;
    tick();
    chk("x_in_wait", 32'(u3.state), 32'(WAIT));
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("x_state", 32'(u3.state), 32'(IDLE));
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (cpu_rvalid3 || dbg_rvalid3 || dm_we3) seen = 1;
      tick();
    end
    chk("x_quiet", 32'(seen), 32'd0);
    cpu_req3 = 1; dbg_req3 = 1; dbg_we = 1;
    #1;
    chk("x_tie_cpu", 32'(cpu_ready3), 32'd1);
    chk("x_tie_dbg", 32'(dbg_ready3), 32'd0);
    tick();
    cpu_req3 = 0; dbg_req3 = 0; dbg_we = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
